binpool2_stream: RTL
====================

# binpool2_stream

Downstream stage of the layer-2 binary accumulate/threshold array. Captures one complete binarized layer-2 feature frame (NCH channels of DIM×DIM bits), applies 2×2 binary max-pool (logical OR) per channel, and streams pooled channels out one per beat over a valid/ready handshake. The output feeds the layer-3 XNOR/popcount front end.

## Interface
- NCH, 60, number of channels per frame
- DIM, 8, input map side length; even, ≥2; pooled side PD = DIM/2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  frame present on in_map
- in_ready  out  1  block can accept a frame this cycle
- in_map  in  [0:NCH*DIM*DIM-1]  frame; channel c at bits c*DIM*DIM .. (c+1)*DIM*DIM-1; pixel (r,k) at offset r*DIM+k
- flush  in  1  synchronous abort of the current frame
- out_valid  out  1  pooled channel present
- out_ready  in  1  consumer accepts this cycle
- out_data  out  [0:PD*PD-1]  pooled channel; bit pr*PD+pc
- out_chan  out  $clog2(NCH)  channel index of out_data
- out_last  out  1  out_chan == NCH-1

## Operation
- States: IDLE, STREAM.
- IDLE: in_ready=1, out_valid=0. On in_valid: latch in_map into frame buffer, ch_cnt←0, go STREAM.
- STREAM: out_valid=1; out_data = pool(buffer channel ch_cnt); out_chan=ch_cnt; out_last=(ch_cnt==NCH-1).
- Pool rule: out bit (pr,pc) = OR of input pixels (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
- Output beat completes when out_valid && out_ready; non-last: ch_cnt←ch_cnt+1. Last: if in_valid same cycle, load new frame, ch_cnt←0, stay STREAM; else go IDLE.
- in_ready = IDLE || (STREAM && out_ready && out_last). in_valid ignored in any other cycle.
- Stall: out_ready=0 holds out_data, out_chan, out_last, buffer and ch_cnt unchanged; no beat lost or duplicated.
- flush=1: next state IDLE, ch_cnt←0; overrides any input or output handshake that cycle (in_ready forced 0 while flush=1). Buffer contents irrelevant after flush.
- Reset (rst_n=0, asynchronous): state IDLE, ch_cnt 0, buffer all-zero; hence out_valid=0, out_data=0, out_chan=0, out_last=0, in_ready=1 (once rst_n deasserted).
- ch_cnt width $clog2(NCH); never exceeds NCH-1.

## Timing
- Frame accepted at edge t → out_valid=1 with channel 0 in cycle after t.
- Full-throughput: out_ready held high gives one channel per cycle; frame of NCH channels drains in NCH cycles.
- Back-to-back frames: last beat and new frame accepted on same edge; no bubble between channel NCH-1 of frame n and channel 0 of frame n+1.
- in_ready combinationally depends on out_ready and state only; out_* depend on registers only (no input-to-output path on data side).

## Structure
- Shared package bnn_pkg: NCH, DIM, PD constants, state enum type.
- Sub-module binpool2x2: combinational DIM×DIM → PD×PD OR-pool of one channel; one instance on the muxed channel (mux before pool, not NCH pool instances).
- Frame buffer NCH*DIM*DIM flops, load-enabled only on accepted frame.

## Test plan
- Reset then frame with channel 0 = all-ones, others zero; out_ready=1 → cycle 1: out_chan=0, out_data=16'hFFFF; next 59 beats out_data=0; out_last only on chan 59; then IDLE, in_ready=1.
- Channel 5 with single pixel (3,6) set → beat 5 out_data has only bit 1*4+3=7 set; all other bits/channels zero.
- Random out_ready (~50%) over random frame → output sequence equals software OR-pool model, channel order 0..59, no drops/dups, out_data stable while stalled.
- in_valid held high with out_ready=1 across two frames → 120 consecutive valid beats, chan wraps 59→0 with no gap; second frame's data correct.
- flush asserted at beat 20 with in_valid=1 → next cycle out_valid=0, in_ready=1; frame not accepted during flush cycle; subsequent frame starts at chan 0.
- rst_n pulsed low mid-stream (beat 30) → out_valid, out_data, out_chan drop to 0 immediately, state IDLE; next frame streams correctly from chan 0.

Source files
------------

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants and state type for the layer-2 binary pooling stage
package bnn_pkg;

    localparam int NCH = 60;
    localparam int DIM = 8;
    localparam int PD  = DIM / 2;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/binpool2x2.sv
// rtl/binpool2x2.sv - combinational 2x2 binary max-pool (OR) of one DIM x DIM channel
module binpool2x2
    import bnn_pkg::*;
(
    input  logic [0:DIM*DIM-1] chan_map,
    output logic [0:PD*PD-1]   pooled
);

    // each pooled bit is the OR of its 2x2 input window
    always_comb begin
        pooled = '0;
        for (int pr = 0; pr < PD; pr++) begin
            for (int pc = 0; pc < PD; pc++) begin
                pooled[pr*PD+pc] = chan_map[(2*pr)*DIM   + 2*pc]
                                 | chan_map[(2*pr)*DIM   + 2*pc + 1]
                                 | chan_map[(2*pr+1)*DIM + 2*pc]
                                 | chan_map[(2*pr+1)*DIM + 2*pc + 1];
            end
        end
    end

endmodule

// File: rtl/binpool2_stream.sv
// rtl/binpool2_stream.sv - frame capture, per-channel 2x2 OR-pool and channel streaming
module binpool2_stream
    import bnn_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:NCH*DIM*DIM-1] in_map,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:PD*PD-1]       out_data,
    output logic [$clog2(NCH)-1:0] out_chan,
    output logic                   out_last
);

    localparam int CW = $clog2(NCH);
    localparam int DD = DIM * DIM;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    state_t                 state;
    logic [CW-1:0]          ch_cnt;
    logic [0:NCH*DD-1]      frame_buf;
    logic [0:DD-1]          cur_chan;
    logic                   at_last;
    logic                   accept;

    assign at_last = (ch_cnt == LAST_CH);

    // a new frame may enter when idle, or on the very edge the last beat leaves
    assign in_ready = !flush && ((state == IDLE) ||
                                 ((state == STREAM) && out_ready && at_last));
    assign accept   = in_valid && in_ready;

    // frame buffer only changes when a frame is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_buf <= '0;
        end else if (accept) begin
            frame_buf <= in_map;
        end
    end

    // control FSM: channel counter walks the buffered frame one beat at a time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ch_cnt <= '0;
        end else if (flush) begin
            state  <= IDLE;
            ch_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state  <= STREAM;
                        ch_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (!at_last) begin
                            ch_cnt <= ch_cnt + 1'b1;
                        end else begin
                            ch_cnt <= '0;
                            state  <= in_valid ? STREAM : IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    ch_cnt <= '0;
                end
            endcase
        end
    end

    // select the current channel first so a single pool instance suffices
    assign cur_chan = frame_buf[ch_cnt*DD +: DD];

    binpool2x2 u_pool (
        .chan_map (cur_chan),
        .pooled   (out_data)
    );

    assign out_valid = (state == STREAM);
    assign out_chan  = ch_cnt;
    assign out_last  = (state == STREAM) && at_last;

endmodule
